// File: rtl/rtp_engine_cfg_regmap.sv
// Configuration register map for a multi-channel RTP streaming engine.
// Software programs per-channel shadow geometry/mode registers. A COMMIT
// write then moves them into the active registers atomically: at once when
// the channel is disabled, otherwise at the next frame boundary.
// The block also holds sticky status, per-channel frame counters and a
// masked level interrupt.
module rtp_engine_cfg_regmap #(
   parameter logic [31:0] VERSION = 32'd2,
   parameter int          NUM_CH  = 4,
   parameter int          LINE_W  = 12
) (
   input  logic                     up_clk,
   input  logic                     up_rst,
   input  logic                     up_wreq,
   input  logic [13:0]              up_waddr,
   input  logic [31:0]              up_wdata,
   output logic                     up_wack,
   input  logic                     up_rreq,
   input  logic [13:0]              up_raddr,
   output logic [31:0]              up_rdata,
   output logic                     up_rack,
   input  logic [NUM_CH-1:0]        frame_start,
   input  logic [NUM_CH-1:0]        frame_done,
   input  logic [NUM_CH-1:0]        ch_overflow,
   output logic [NUM_CH*LINE_W-1:0] num_lines,
   output logic [NUM_CH*LINE_W-1:0] num_px_p_line,
   output logic [NUM_CH*4-1:0]      ts_mode,
   output logic [NUM_CH-1:0]        ch_enable,
   output logic                     irq
);

   // Global registers
   logic [31:0]       scratch_q, scratch_d;
   logic [NUM_CH-1:0] irq_mask_q, irq_mask_d;
   logic [NUM_CH-1:0] pending_q, pending_d;

   // Per-channel shadow (software-visible) registers
   logic [LINE_W-1:0] sh_lines_q [NUM_CH];
   logic [LINE_W-1:0] sh_lines_d [NUM_CH];
   logic [LINE_W-1:0] sh_px_q    [NUM_CH];
   logic [LINE_W-1:0] sh_px_d    [NUM_CH];
   logic [4:0]        sh_ctrl_q  [NUM_CH];
   logic [4:0]        sh_ctrl_d  [NUM_CH];

   // Per-channel active registers driving the datapath
   logic [LINE_W-1:0] act_lines_q [NUM_CH];
   logic [LINE_W-1:0] act_lines_d [NUM_CH];
   logic [LINE_W-1:0] act_px_q    [NUM_CH];
   logic [LINE_W-1:0] act_px_d    [NUM_CH];
   logic [3:0]        act_mode_q  [NUM_CH];
   logic [3:0]        act_mode_d  [NUM_CH];
   logic [NUM_CH-1:0] act_en_q, act_en_d;

   // Per-channel status and frame counters
   logic [1:0]        status_q    [NUM_CH];
   logic [1:0]        status_d    [NUM_CH];
   logic [31:0]       frame_cnt_q [NUM_CH];
   logic [31:0]       frame_cnt_d [NUM_CH];

   // Bus response registers
   logic              wack_q, rack_q, irq_q, irq_d;
   logic [31:0]       rdata_q, rdata_d, rd_val;

   // Decode helpers
   logic              w_glob;
   logic [NUM_CH-1:0] w_ch;
   logic [NUM_CH-1:0] copy_now;
   logic [NUM_CH-1:0] count_now;
   logic [NUM_CH-1:0] status_any;

   // Write decode: the global page is 0x00-0x0F, channel c lives in page c+1
   always_comb begin
      w_glob = up_wreq && (up_waddr[13:4] == 10'd0);
      w_ch   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_ch[c] = up_wreq && (up_waddr[13:8] == 6'd0) && (up_waddr[7:4] == 4'(c + 1));
      end
   end

   // Next-state for all registers; a commit copy always uses the pre-edge shadow
   always_comb begin
      scratch_d  = scratch_q;
      irq_mask_d = irq_mask_q;
      pending_d  = pending_q;
      act_en_d   = act_en_q;
      copy_now   = '0;
      count_now  = '0;
      status_any = '0;
      if (w_glob && up_waddr[3:0] == 4'd2) scratch_d  = up_wdata;
      if (w_glob && up_waddr[3:0] == 4'd4) irq_mask_d = up_wdata[NUM_CH-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
         sh_lines_d[c]  = sh_lines_q[c];
         sh_px_d[c]     = sh_px_q[c];
         sh_ctrl_d[c]   = sh_ctrl_q[c];
         act_lines_d[c] = act_lines_q[c];
         act_px_d[c]    = act_px_q[c];
         act_mode_d[c]  = act_mode_q[c];
         status_d[c]    = status_q[c];
         frame_cnt_d[c] = frame_cnt_q[c];
         status_any[c]  = (status_q[c] != 2'b00);

         // A disabled channel applies at once; an enabled one waits for frame_start
         copy_now[c]  = pending_q[c] && (!act_en_q[c] || frame_start[c]);
         count_now[c] = frame_done[c] && act_en_q[c];

         if (copy_now[c]) begin
            act_lines_d[c] = sh_lines_q[c];
            act_px_d[c]    = sh_px_q[c];
            act_mode_d[c]  = sh_ctrl_q[c][3:0];
            act_en_d[c]    = sh_ctrl_q[c][4];
            pending_d[c]   = 1'b0;
         end
         // A new COMMIT landing on the same edge as a copy re-arms the channel
         if (w_glob && up_waddr[3:0] == 4'd3 && up_wdata[c]) pending_d[c] = 1'b1;

         if (w_ch[c]) begin
            case (up_waddr[3:0])
               4'd0:    sh_lines_d[c] = up_wdata[LINE_W-1:0];
               4'd1:    sh_px_d[c]    = up_wdata[LINE_W-1:0];
               4'd2:    sh_ctrl_d[c]  = up_wdata[4:0];
               4'd3:    status_d[c]   = status_q[c] & ~up_wdata[1:0];
               4'd4:    frame_cnt_d[c] = 32'd0;
               default: ;
            endcase
         end
         // Set events are applied after the W1C so they win a same-cycle clear
         status_d[c] = status_d[c] | {copy_now[c], ch_overflow[c]};
         frame_cnt_d[c] = frame_cnt_d[c] + {31'd0, count_now[c]};
      end
      irq_d = |(irq_mask_q & status_any);
   end

   // Read mux: unmapped locations return zero
   always_comb begin
      rd_val = 32'd0;
      if (up_raddr[13:8] == 6'd0) begin
         if (up_raddr[7:4] == 4'd0) begin
            case (up_raddr[3:0])
               4'd0:    rd_val = VERSION;
               4'd1:    rd_val = {16'(LINE_W), 16'(NUM_CH)};
               4'd2:    rd_val = scratch_q;
               4'd3:    rd_val = 32'(pending_q);
               4'd4:    rd_val = 32'(irq_mask_q);
               default: rd_val = 32'd0;
            endcase
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (up_raddr[7:4] == 4'(c + 1)) begin
               case (up_raddr[3:0])
                  4'd0:    rd_val = 32'(sh_lines_q[c]);
                  4'd1:    rd_val = 32'(sh_px_q[c]);
                  4'd2:    rd_val = 32'(sh_ctrl_q[c]);
                  4'd3:    rd_val = 32'(status_q[c]);
                  4'd4:    rd_val = frame_cnt_q[c];
                  default: rd_val = 32'd0;
               endcase
            end
         end
      end
      rdata_d = up_rreq ? rd_val : rdata_q;
   end

   // State registers; reset clears everything including any in-flight commit
   always_ff @(posedge up_clk or posedge up_rst) begin
      if (up_rst) begin
         scratch_q  <= '0;
         irq_mask_q <= '0;
         pending_q  <= '0;
         act_en_q   <= '0;
         wack_q     <= 1'b0;
         rack_q     <= 1'b0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            sh_lines_q[c]  <= '0;
            sh_px_q[c]     <= '0;
            sh_ctrl_q[c]   <= '0;
            act_lines_q[c] <= '0;
            act_px_q[c]    <= '0;
            act_mode_q[c]  <= '0;
            status_q[c]    <= '0;
            frame_cnt_q[c] <= '0;
         end
      end else begin
         scratch_q  <= scratch_d;
         irq_mask_q <= irq_mask_d;
         pending_q  <= pending_d;
         act_en_q   <= act_en_d;
         wack_q     <= up_wreq;
         rack_q     <= up_rreq;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
         for (int c = 0; c < NUM_CH; c++) begin
            sh_lines_q[c]  <= sh_lines_d[c];
            sh_px_q[c]     <= sh_px_d[c];
            sh_ctrl_q[c]   <= sh_ctrl_d[c];
            act_lines_q[c] <= act_lines_d[c];
            act_px_q[c]    <= act_px_d[c];
            act_mode_q[c]  <= act_mode_d[c];
            status_q[c]    <= status_d[c];
            frame_cnt_q[c] <= frame_cnt_d[c];
         end
      end
   end

   assign up_wack   = wack_q;
   assign up_rack   = rack_q;
   assign up_rdata  = rdata_q;
   assign irq       = irq_q;
   assign ch_enable = act_en_q;

   // Pack per-channel active registers onto the flat output buses
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
      assign num_lines[gi*LINE_W +: LINE_W]     = act_lines_q[gi];
      assign num_px_p_line[gi*LINE_W +: LINE_W] = act_px_q[gi];
      assign ts_mode[gi*4 +: 4]                 = act_mode_q[gi];
   end

endmodule
